fir_response_capture: RTL and testbench

//   Sink at the output end of the N-tap FIR path: on arm, waits for a start

---
 rtl/fir_response_capture.sv | 145 ++++++++++++++
 tb/tb_fir_response_capture.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_response_capture.sv
// Captures DEPTH consecutive FIR output samples after a start condition and streams them out over valid/ready.
// Optional peak-magnitude tracker enabled by defining PEAK_TRACK_EN.
module fir_response_capture #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_vld,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig_en,
  input  logic [DATA_W-1:0] trig_thr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] peak_abs,
  output logic [ADDR_W-1:0] peak_idx
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, READOUT} state_t;

  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] FULL_PTR = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              start_hit;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;

  // The trigger sample itself is stored at index 0 in the same cycle it is seen.
  always_comb begin
    start_hit = !trig_en || ($signed(sample_in) >= $signed(trig_thr));
    wr_en     = !abort && sample_vld &&
                (((state == ARMED) && start_hit) || (state == CAPTURE));
    wr_addr   = (state == ARMED) ? '0 : wr_ptr[ADDR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= sample_in;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state    <= IDLE;
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (arm) begin
              state  <= ARMED;
              wr_ptr <= '0;
              rd_ptr <= '0;
            end
          end
          ARMED: begin
            if (wr_en) begin
              wr_ptr <= (ADDR_W+1)'(1);
              state  <= (DEPTH == 1) ? READOUT : CAPTURE;
            end
          end
          CAPTURE: begin
            if (wr_en) begin
              wr_ptr <= wr_ptr + 1'b1;
              if (wr_ptr == LAST_PTR) state <= READOUT;
            end
          end
          READOUT: begin
            // Output register refills whenever empty or being drained, giving full-rate streaming.
            if (rd_valid && rd_ready && rd_last) begin
              rd_valid <= 1'b0;
              rd_last  <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end else if ((!rd_valid || rd_ready) && (rd_ptr != FULL_PTR)) begin
              rd_data  <= mem[rd_ptr[ADDR_W-1:0]];
              rd_valid <= 1'b1;
              rd_last  <= (rd_ptr == LAST_PTR);
              rd_ptr   <= rd_ptr + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef PEAK_TRACK_EN
  logic [DATA_W-1:0] sample_abs;

  // Most negative value has no positive counterpart, so it saturates.
  always_comb begin
    sample_abs = sample_in;
    if (sample_in[DATA_W-1]) begin
      if (sample_in == {1'b1, {(DATA_W-1){1'b0}}})
        sample_abs = {1'b0, {(DATA_W-1){1'b1}}};
      else
        sample_abs = ~sample_in + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      peak_abs <= '0;
      peak_idx <= '0;
    end else if (!abort) begin
      if ((state == IDLE) && arm) begin
        peak_abs <= '0;
        peak_idx <= '0;
      end else if (wr_en && (sample_abs > peak_abs)) begin
        peak_abs <= sample_abs;
        peak_idx <= wr_addr;
      end
    end
  end
`else
  assign peak_abs = '0;
  assign peak_idx = '0;
`endif

endmodule

// File: tb/tb_fir_response_capture.sv
// Directed self-checking bench for fir_response_capture at DEPTH=8.
// Peak expectations follow PEAK_TRACK_EN when it is defined for the build.
module tb_fir_response_capture;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] sample_in;
  logic              sample_vld;
  logic              arm;
  logic              abort;
  logic              trig_en;
  logic [DATA_W-1:0] trig_thr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              rd_last;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] peak_abs;
  logic [ADDR_W-1:0] peak_idx;

  int tests_run    = 0;
  int tests_failed = 0;

  fir_response_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_vld(sample_vld),
    .arm(arm), .abort(abort), .trig_en(trig_en), .trig_thr(trig_thr),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .busy(busy), .done(done), .peak_abs(peak_abs), .peak_idx(peak_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  function automatic logic [15:0] s16(input int v);
    return v[15:0];
  endfunction

  task automatic applyStimulus(input logic [15:0] s[$], input bit gap3, input bit arm_mid);
    int c = 0;
    foreach (s[i]) begin
      if (gap3 && (c % 3 == 2)) begin
        sample_in  = 16'h5555;
        sample_vld = 1'b0;
        arm        = arm_mid;
        tick;
        arm = 1'b0;
        c++;
      end
      sample_in  = s[i];
      sample_vld = 1'b1;
      tick;
      c++;
    end
    sample_vld = 1'b0;
    sample_in  = '0;
  endtask

  task automatic armCapture;
    arm = 1'b1;
    tick;
    arm = 1'b0;
    checkOutput("busy_after_arm", 32'(busy), 1);
  endtask

  task automatic runCapture(input logic [15:0] s[$], input logic [15:0] e[$],
                            input bit gap3, input bit arm_mid);
    armCapture;
    applyStimulus(s, gap3, arm_mid);
    checkOutput("readout_entry_valid", 32'(rd_valid), 0);
    checkOutput("readout_entry_busy", 32'(busy), 1);
    tick;
    checkOutput("first_valid", 32'(rd_valid), 1);
    checkOutput("first_data", {16'b0, rd_data}, {16'b0, e[0]});
  endtask

  task automatic drainReadout(input logic [15:0] e[$], input bit stall);
    bit          pat [6];
    int          n = 0;
    int          k = 0;
    bit          held = 1'b0;
    logic [15:0] hd = '0;
    logic        hl = 1'b0;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    while (n < e.size() && k < 200) begin
      if (held) begin
        checkOutput("stall_valid", 32'(rd_valid), 1);
        checkOutput("stall_data", {16'b0, rd_data}, {16'b0, hd});
        checkOutput("stall_last", 32'(rd_last), 32'(hl));
      end
      rd_ready = stall ? pat[k % 6] : 1'b1;
      held = 1'b0;
      if (rd_valid) begin
        if (rd_ready) begin
          checkOutput($sformatf("rd_data[%0d]", n), {16'b0, rd_data}, {16'b0, e[n]});
          checkOutput($sformatf("rd_last[%0d]", n), 32'(rd_last), 32'(n == e.size() - 1));
          n++;
        end else begin
          held = 1'b1;
          hd   = rd_data;
          hl   = rd_last;
        end
      end
      tick;
      k++;
    end
    rd_ready = 1'b0;
    checkOutput("transfer_count", n, e.size());
    checkOutput("done_pulse", 32'(done), 1);
    checkOutput("rd_valid_after_last", 32'(rd_valid), 0);
    checkOutput("busy_after_done", 32'(busy), 0);
    tick;
    checkOutput("done_one_cycle", 32'(done), 0);
  endtask

  initial begin
    logic [15:0] s[$];
    logic [15:0] e[$];
    int exp_peak;
    int exp_idx;

    rst = 1'b0; sample_in = '0; sample_vld = 1'b0; arm = 1'b0; abort = 1'b0;
    trig_en = 1'b0; trig_thr = '0; rd_ready = 1'b0;
    tick; tick;
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_rd_valid", 32'(rd_valid), 0);
    checkOutput("reset_rd_last", 32'(rd_last), 0);
    checkOutput("reset_rd_data", {16'b0, rd_data}, 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_peak_abs", {16'b0, peak_abs}, 0);
    checkOutput("reset_peak_idx", 32'(peak_idx), 0);
    rst = 1'b1;
    tick;

    // Impulse-like response, free-running start
    s = '{16'd1, 16'd2, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    runCapture(s, s, 1'b0, 1'b0);
    drainReadout(s, 1'b0);

    // Threshold start on a ramp
    trig_en = 1'b1; trig_thr = 16'd100;
    s = {}; e = {};
    for (int v = 90; v <= 135; v += 5) s.push_back(s16(v));
    for (int v = 100; v <= 135; v += 5) e.push_back(s16(v));
    runCapture(s, e, 1'b0, 1'b0);
    drainReadout(e, 1'b0);
    trig_en = 1'b0;

    // Reader stalls
    s = '{16'd21, 16'd22, 16'd23, 16'd24, 16'd25, 16'd26, 16'd27, 16'd28};
    runCapture(s, s, 1'b0, 1'b0);
    drainReadout(s, 1'b1);

    // Gapped input with a stray arm while busy
    s = '{16'd11, 16'd12, 16'd13, 16'd14, 16'd15, 16'd16, 16'd17, 16'd18};
    runCapture(s, s, 1'b1, 1'b1);
    drainReadout(s, 1'b0);

    // arm and abort together in IDLE
    arm = 1'b1; abort = 1'b1;
    tick;
    arm = 1'b0; abort = 1'b0;
    checkOutput("arm_abort_busy", 32'(busy), 0);
    tick;
    checkOutput("arm_abort_busy_later", 32'(busy), 0);

    // Abort during readout after three transfers
    s = '{16'd31, 16'd32, 16'd33, 16'd34, 16'd35, 16'd36, 16'd37, 16'd38};
    runCapture(s, s, 1'b0, 1'b0);
    rd_ready = 1'b1;
    tick; tick; tick;
    checkOutput("abort_pre_data", {16'b0, rd_data}, 34);
    rd_ready = 1'b0; abort = 1'b1;
    tick;
    abort = 1'b0;
    checkOutput("abort_rd_valid", 32'(rd_valid), 0);
    checkOutput("abort_rd_last", 32'(rd_last), 0);
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_done", 32'(done), 0);
    tick;
    checkOutput("abort_no_done_later", 32'(done), 0);

    // Asynchronous reset mid-capture, then a fresh run
    armCapture;
    s = '{16'd1, 16'd2, 16'd3};
    applyStimulus(s, 1'b0, 1'b0);
    checkOutput("mid_capture_busy", 32'(busy), 1);
    rst = 1'b0;
    #1;
    checkOutput("async_rst_busy", 32'(busy), 0);
    checkOutput("async_rst_rd_valid", 32'(rd_valid), 0);
    checkOutput("async_rst_rd_data", {16'b0, rd_data}, 0);
    checkOutput("async_rst_peak_abs", {16'b0, peak_abs}, 0);
    tick;
    rst = 1'b1;
    tick;
    s = '{16'd41, 16'd42, 16'd43, 16'd44, 16'd45, 16'd46, 16'd47, 16'd48};
    runCapture(s, s, 1'b0, 1'b0);
    drainReadout(s, 1'b0);

    // Peak tracking, including repeated and most-negative samples
    s = '{s16(10), s16(200), s16(-300), s16(-300), s16(5), 16'd0, 16'd0, 16'd0};
`ifdef PEAK_TRACK_EN
    exp_peak = 300; exp_idx = 2;
`else
    exp_peak = 0; exp_idx = 0;
`endif
    runCapture(s, s, 1'b0, 1'b0);
    checkOutput("peak_abs_readout", {16'b0, peak_abs}, exp_peak);
    checkOutput("peak_idx_readout", 32'(peak_idx), exp_idx);
    drainReadout(s, 1'b0);
    checkOutput("peak_abs_after_done", {16'b0, peak_abs}, exp_peak);
    checkOutput("peak_idx_after_done", 32'(peak_idx), exp_idx);

    s = '{16'd0, s16(-32768), 16'd100, s16(-5), 16'd0, 16'd0, 16'd0, 16'd0};
`ifdef PEAK_TRACK_EN
    exp_peak = 32767; exp_idx = 1;
`else
    exp_peak = 0; exp_idx = 0;
`endif
    runCapture(s, s, 1'b0, 1'b0);
    checkOutput("peak_abs_saturate", {16'b0, peak_abs}, exp_peak);
    checkOutput("peak_idx_saturate", 32'(peak_idx), exp_idx);
    drainReadout(s, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
